mem_access_stage: RTL and testbench

//  Memory-access stage directly downstream of the ALU: consumes ALU_result (as effective address for LW/SW, or as pass-through result otherwise) plus rt_content (store data).

---
 rtl/mem_access_stage_pkg.sv | 20 ++
 rtl/mem_access_stage_mem_timeout_counter.sv | 27 ++
 rtl/mem_access_stage.sv | 148 ++++++++++++++
 tb/tb_mem_access_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: opcodes, FSM encoding, width defaults.
package mem_access_stage_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_stage_mem_timeout_counter.sv
// Counts cycles an access has waited for mem_ack; expired fires on the cycle the wait reaches TIMEOUT_CYCLES.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != CNT_W'(TIMEOUT_CYCLES))) begin
      count <= count + CNT_W'(1);
    end
  end

  // count holds the number of completed waiting cycles, so this is the last allowed one
  assign expired = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues LW/SW on a req/ack port, passes other results through, one record in flight.
// Optional MEM_ALIGN_CHECK_EN: misaligned LW/SW are rejected without a memory request and flagged on misalign.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       rt_content,
  input  logic [4:0]        wb_reg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_wb_reg,
  output logic              out_wb_en,
  output logic              mem_timeout
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  state_t state;
  logic   is_lw;
  logic   addr_misaligned;
  logic   cnt_clear;
  logic   cnt_en;
  logic   cnt_expired;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_misaligned = |ALU_result[1:0];
`else
  assign addr_misaligned = 1'b0;
`endif

  assign cnt_clear = (state != ST_ACCESS);
  assign cnt_en    = (state == ST_ACCESS) && !mem_ack;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .expired(cnt_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      is_lw       <= 1'b0;
      in_ready    <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_wb_reg  <= '0;
      out_wb_en   <= 1'b0;
      mem_timeout <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
    end else begin
      mem_timeout <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
      case (state)
        // Accept boundary: latch the record and decide memory vs. pass-through
        ST_IDLE: begin
          if (in_valid) begin
            in_ready   <= 1'b0;
            out_wb_reg <= wb_reg;
            is_lw      <= (opcode == OP_LW);
            if (is_mem_op(opcode) && !addr_misaligned) begin
              state     <= ST_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= (opcode == OP_SW);
              mem_addr  <= ALU_result[ADDR_W-1:0];
              mem_wdata <= DATA_W'(rt_content);
            end else if (is_mem_op(opcode)) begin
              state     <= ST_RESP;
              out_valid <= 1'b1;
              out_data  <= '0;
              out_wb_en <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
              misalign  <= 1'b1;
`endif
            end else begin
              state     <= ST_RESP;
              out_valid <= 1'b1;
              out_data  <= DATA_W'(ALU_result);
              out_wb_en <= 1'b1;
            end
          end
        end
        // Memory boundary: request held stable until ack or timeout
        ST_ACCESS: begin
          if (mem_ack) begin
            state     <= ST_RESP;
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= is_lw ? mem_rdata : '0;
            out_wb_en <= is_lw;
          end else if (cnt_expired) begin
            state       <= ST_RESP;
            mem_req     <= 1'b0;
            mem_timeout <= 1'b1;
            out_valid   <= 1'b1;
            out_data    <= '0;
            out_wb_en   <= 1'b0;
          end
        end
        // Write-back boundary: record held until downstream takes it
        ST_RESP: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          mem_req   <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected write-back records queued at issue, compared at handshake.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [31:0]       ALU_result;
  logic [31:0]       rt_content;
  logic [4:0]        wb_reg;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_wb_reg;
  logic              out_wb_en;
  logic              mem_timeout;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misalign;
`endif

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        wen;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_r;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .ALU_result (ALU_result),
    .rt_content (rt_content),
    .wb_reg     (wb_reg),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_wb_reg (out_wb_reg),
    .out_wb_en  (out_wb_en),
    .mem_timeout(mem_timeout)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign   (misalign)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Scoreboard: compare every accepted write-back record with the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_r = exp_q.pop_front();
        check_val("sb_data", out_data, mon_r.data);
        check_val("sb_wb_reg", {27'd0, out_wb_reg}, {27'd0, mon_r.wreg});
        check_val("sb_wb_en", {31'd0, out_wb_en}, {31'd0, mon_r.wen});
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic [4:0] r, input logic e);
    rec_t x;
    x.data = d;
    x.wreg = r;
    x.wen  = e;
    exp_q.push_back(x);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt,
                      input logic [4:0] r);
    bit ok = 1'b0;
    opcode     = op;
    ALU_result = alu;
    rt_content = rt;
    wb_reg     = r;
    in_valid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Memory responder: acks during the delay-th request cycle, checking the request stays stable
  task automatic mem_serve(input int delay, input logic [31:0] rdata, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 1; i <= delay; i++) begin
      @(negedge clk);
      check_val("req_held", {31'd0, mem_req}, 32'd1);
      check_val("req_we", {31'd0, mem_we}, {31'd0, we});
      check_val("req_addr", mem_addr, addr);
      if (we) check_val("req_wdata", mem_wdata, wdata);
      if (i == delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
    end
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check_val("req_drop", {31'd0, mem_req}, 32'd0);
    check_val("resp_valid", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    opcode     = '0;
    ALU_result = '0;
    rt_content = '0;
    wb_reg     = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    check_val("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pass-through R-type
    send(6'b000000, 32'd27, 32'd0, 5'd3);
    push_exp(32'd27, 5'd3, 1'b1);
    @(negedge clk);
    check_val("rtype_latency", {31'd0, out_valid}, 32'd1);
    check_val("rtype_no_req", {31'd0, mem_req}, 32'd0);
    check_val("rtype_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;

    // Load with ack in the third request cycle
    send(OP_LW, 32'h20, 32'h0, 5'd5);
    push_exp(32'hDEADBEEF, 5'd5, 1'b1);
    mem_serve(3, 32'hDEADBEEF, 1'b0, 32'h20, 32'h0);
    @(posedge clk);
    #1;

    // Store with downstream stalled for 4 cycles
    out_ready = 1'b0;
    send(OP_SW, 32'h24, 32'h12345678, 5'd7);
    push_exp(32'h0, 5'd7, 1'b0);
    mem_serve(2, 32'hFFFF_FFFF, 1'b1, 32'h24, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      check_val("stall_valid", {31'd0, out_valid}, 32'd1);
      check_val("stall_wb_en", {31'd0, out_wb_en}, 32'd0);
      check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;

    // Load that never gets acked
    send(OP_LW, 32'h40, 32'h0, 5'd9);
    push_exp(32'h0, 5'd9, 1'b0);
    n = 0;
    @(negedge clk);
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_val("timeout_req_cycles", n, 32'd16);
    check_val("timeout_pulse", {31'd0, mem_timeout}, 32'd1);
    check_val("timeout_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    @(negedge clk);
    check_val("timeout_pulse_end", {31'd0, mem_timeout}, 32'd0);
    check_val("late_ack_no_req", {31'd0, mem_req}, 32'd0);
    check_val("late_ack_no_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;

    // Reset in the middle of an access, followed by a stray ack
    send(OP_LW, 32'h50, 32'h0, 5'd11);
    @(negedge clk);
    check_val("mid_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("midrst_mem_addr", mem_addr, 32'd0);
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_wb_en", {31'd0, out_wb_en}, 32'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check_val("stray_ack_no_valid", {31'd0, out_valid}, 32'd0);
    check_val("stray_ack_no_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1;

    // Pass-through with all-ones value after recovery
    send(6'b001000, 32'hFFFF_FFFF, 32'h0, 5'd31);
    push_exp(32'hFFFF_FFFF, 5'd31, 1'b1);
    @(negedge clk);
    check_val("addi_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

`ifdef MEM_ALIGN_CHECK_EN
    send(OP_LW, 32'h22, 32'h0, 5'd4);
    push_exp(32'h0, 5'd4, 1'b0);
    @(negedge clk);
    check_val("misalign_pulse", {31'd0, misalign}, 32'd1);
    check_val("misalign_no_req", {31'd0, mem_req}, 32'd0);
    check_val("misalign_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
`endif

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_val("sb_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
